pwm_rx_decoder: RTL

Receive-side demodulator for the single-lane pulse-width-modulated link, opposite the PWM TX driver. The driver encodes each 4-bit symbol as a pulse high-time of BASE + code units, prefixes each burst with a marker pulse that carries a 4-bit frame index, and separates bursts with a long low gap. This block synchronizes the comparator output, measures pulse and gap durations on an oversampling clock (1 clk period = 1 Tunit), and classifies marker and data pulses. Decoded symbols are delivered through a small FIFO with a valid/ready handshake to the link-layer deserializer.

---
 rtl/pwm_rx_pkg.sv | 20 ++
 rtl/pwm_sym_fifo.sv | 81 ++++++++
 rtl/pwm_rx_decoder.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/pwm_rx_pkg.sv
// Shared types for the PWM receive path: FSM state encoding and the symbol
// record carried through the output FIFO.
package pwm_rx_pkg;

  localparam int unsigned SYM_W = 4;

  typedef enum logic [1:0] {
    SEARCH,
    GAP,
    MARK,
    DATA
  } pwm_rx_state_t;

  typedef struct packed {
    logic             sof;
    logic             err;
    logic [SYM_W-1:0] data;
  } pwm_sym_t;

endpackage

// File: rtl/pwm_sym_fifo.sv
// Synchronous symbol FIFO with registered head and registered full/empty flags.
// A push while full is accepted only when a pop frees a slot in the same cycle.
module pwm_sym_fifo
  import pwm_rx_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic     clk,
  input  logic     rstn,
  input  logic     push,
  input  pwm_sym_t push_data,
  input  logic     pop,
  output pwm_sym_t head,
  output logic     full,
  output logic     empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_C = (AW+1)'(DEPTH);

  pwm_sym_t      mem_q [DEPTH];
  pwm_sym_t      mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  pwm_sym_t      head_q, head_d;
  logic          full_q, full_d;
  logic          empty_q, empty_d;
  logic          push_ok;
  logic          pop_ok;

  always_comb begin
    pop_ok   = pop & ~empty_q;
    push_ok  = push & (~full_q | pop_ok);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push_ok, pop_ok})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
    // Head is taken from next-state storage so a first push is visible one cycle later.
    head_d  = mem_d[rd_ptr_d];
    empty_d = (cnt_d == '0);
    full_d  = (cnt_d == FULL_C);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      head_q   <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      head_q   <= head_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  assign head  = head_q;
  assign full  = full_q;
  assign empty = empty_q;

endmodule

// File: rtl/pwm_rx_decoder.sv
// PWM link receiver: synchronizes the sliced line, measures high/low widths,
// decodes marker and data pulses, and queues symbols for the deserializer.
module pwm_rx_decoder
  import pwm_rx_pkg::*;
#(
  parameter int unsigned CNT_W      = 6,
  parameter int unsigned BASE       = 4,
  parameter int unsigned GAP_MIN    = 16,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in,
  output logic [SYM_W-1:0] sym_data,
  output logic             sym_sof,
  output logic             sym_err,
  output logic             sym_valid,
  input  logic             sym_ready,
  output logic [SYM_W-1:0] frame_id,
  output logic             frame_id_valid,
  output logic             overflow,
  input  logic             ovf_clr
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);
  localparam logic [CNT_W-1:0] BASE_C  = CNT_W'(BASE);
  localparam logic [CNT_W-1:0] TOP_C   = CNT_W'(BASE + (2**SYM_W) - 1);
  localparam logic [CNT_W-1:0] GAP_C   = CNT_W'(GAP_MIN);

  logic             in_meta_q, in_meta_d;
  logic             in_s_q, in_s_d;
  logic             in_d_q, in_d_d;
  logic [CNT_W-1:0] hi_cnt_q, hi_cnt_d;
  logic [CNT_W-1:0] lo_cnt_q, lo_cnt_d;
  pwm_rx_state_t    state_q, state_d;
  logic             sof_pend_q, sof_pend_d;
  logic [SYM_W-1:0] frame_id_q, frame_id_d;
  logic             fid_valid_q, fid_valid_d;
  logic             overflow_q, overflow_d;

  logic             rise;
  logic             fall;
  logic             gap_hit;
  logic             in_range;
  logic [SYM_W-1:0] code;
  logic             push;
  pwm_sym_t         push_sym;
  logic             drop;
  pwm_sym_t         fifo_head;
  logic             fifo_full;
  logic             fifo_empty;

  always_comb begin
    in_meta_d = in;
    in_s_d    = in_meta_q;
    in_d_d    = in_s_q;
  end

  assign rise = in_s_q & ~in_d_q;
  assign fall = ~in_s_q & in_d_q;

  always_comb begin
    hi_cnt_d = hi_cnt_q;
    if (rise) begin
      hi_cnt_d = ONE_C;
    end else if (in_s_q && (hi_cnt_q != CNT_MAX)) begin
      hi_cnt_d = hi_cnt_q + ONE_C;
    end
    lo_cnt_d = lo_cnt_q;
    if (fall) begin
      lo_cnt_d = ONE_C;
    end else if (!in_s_q && (lo_cnt_q != CNT_MAX)) begin
      lo_cnt_d = lo_cnt_q + ONE_C;
    end
  end

  // Gap is declared the cycle lo_cnt is about to become GAP_MIN, so a rise right after
  // exactly GAP_MIN low cycles is already seen in GAP.
  assign gap_hit  = ~in_s_q & (lo_cnt_d == GAP_C);
  assign in_range = (hi_cnt_q >= BASE_C) && (hi_cnt_q <= TOP_C);
  assign code     = SYM_W'(hi_cnt_q - BASE_C);

  always_comb begin
    state_d       = state_q;
    sof_pend_d    = sof_pend_q;
    frame_id_d    = frame_id_q;
    fid_valid_d   = 1'b0;
    push          = 1'b0;
    push_sym.sof  = sof_pend_q;
    push_sym.err  = ~in_range;
    push_sym.data = in_range ? code : '0;
    case (state_q)
      SEARCH: begin
        if (gap_hit) state_d = GAP;
      end
      GAP: begin
        if (rise) state_d = MARK;
      end
      MARK: begin
        if (fall) begin
          if (in_range) begin
            frame_id_d  = code;
            fid_valid_d = 1'b1;
            sof_pend_d  = 1'b1;
            state_d     = DATA;
          end else begin
            state_d = SEARCH;
          end
        end
      end
      DATA: begin
        if (fall) begin
          push       = 1'b1;
          sof_pend_d = 1'b0;
        end else if (gap_hit) begin
          state_d = GAP;
        end
      end
      default: state_d = SEARCH;
    endcase
  end

  assign drop = push & fifo_full & ~(sym_ready & ~fifo_empty);

  always_comb begin
    overflow_d = overflow_q;
    if (ovf_clr) overflow_d = 1'b0;
    if (drop)    overflow_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= SEARCH;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      in_meta_q   <= 1'b0;
      in_s_q      <= 1'b0;
      in_d_q      <= 1'b0;
      hi_cnt_q    <= '0;
      lo_cnt_q    <= '0;
      sof_pend_q  <= 1'b0;
      frame_id_q  <= '0;
      fid_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      in_meta_q   <= in_meta_d;
      in_s_q      <= in_s_d;
      in_d_q      <= in_d_d;
      hi_cnt_q    <= hi_cnt_d;
      lo_cnt_q    <= lo_cnt_d;
      sof_pend_q  <= sof_pend_d;
      frame_id_q  <= frame_id_d;
      fid_valid_q <= fid_valid_d;
      overflow_q  <= overflow_d;
    end
  end

  pwm_sym_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rstn     (rstn),
    .push     (push),
    .push_data(push_sym),
    .pop      (sym_ready),
    .head     (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  assign sym_data       = fifo_head.data;
  assign sym_sof        = fifo_head.sof;
  assign sym_err        = fifo_head.err;
  assign sym_valid      = ~fifo_empty;
  assign frame_id       = frame_id_q;
  assign frame_id_valid = fid_valid_q;
  assign overflow       = overflow_q;

endmodule
